// File: rtl/tag_match_pipe.sv
// Two-stage N-way tag comparator for one cache set with valid/ready handshakes.
// Stage 1 registers the per-way match vector; stage 2 holds the prioritised result and the statistics.
module tag_match_pipe #(
   parameter int WAYS   = 8,
   parameter int TAG_W  = 8,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [TAG_W-1:0]          req_tag,
   input  logic [WAYS-1:0]           way_valid,
   input  logic [WAYS*TAG_W-1:0]     way_tag,
   input  logic [WAYS*DATA_W-1:0]    way_data,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic                      hit,
   output logic                      multi_hit,
   output logic [WAYS-1:0]           hit_onehot,
   output logic [$clog2(WAYS)-1:0]   hit_way,
   output logic [DATA_W-1:0]         line_data,
   input  logic                      stats_clear,
   output logic [CNT_W-1:0]          hit_count,
   output logic [CNT_W-1:0]          miss_count
);

   localparam int WAY_W = $clog2(WAYS);

   logic                   s1_valid_reg;
   logic [WAYS-1:0]        s1_match_reg;
   logic [WAYS*DATA_W-1:0] s1_data_reg;

   logic                   s2_valid_reg;
   logic                   hit_reg;
   logic                   multi_reg;
   logic [WAYS-1:0]        onehot_reg;
   logic [WAY_W-1:0]       way_reg;
   logic [DATA_W-1:0]      data_reg;
   logic [CNT_W-1:0]       hit_cnt_reg;
   logic [CNT_W-1:0]       miss_cnt_reg;

   logic [WAYS-1:0]        match;
   logic [WAYS-1:0]        onehot_next;
   logic [WAY_W-1:0]       way_next;
   logic [DATA_W-1:0]      data_next;
   logic                   multi_next;
   logic                   hit_next;
   logic                   s2_adv;
   logic                   accept;
   logic                   consume;

   genvar gi;
   generate
      for (gi = 0; gi < WAYS; gi++) begin : g_cmp
         assign match[gi] = way_valid[gi] && (way_tag[gi*TAG_W +: TAG_W] == req_tag);
      end
   endgenerate

   // Lowest matching way wins; any later match marks a multi-hit.
   always_comb begin
      logic found;
      found       = 1'b0;
      onehot_next = '0;
      way_next    = '0;
      data_next   = '0;
      multi_next  = 1'b0;
      for (int i = 0; i < WAYS; i++) begin
         if (s1_match_reg[i]) begin
            if (found) begin
               multi_next = 1'b1;
            end else begin
               onehot_next[i] = 1'b1;
               way_next       = WAY_W'(i);
               data_next      = s1_data_reg[i*DATA_W +: DATA_W];
            end
            found = 1'b1;
         end
      end
   end

   assign hit_next  = |s1_match_reg;
   assign s2_adv    = !s2_valid_reg || resp_ready;
   assign req_ready = !s1_valid_reg || s2_adv;
   assign accept    = req_valid && req_ready;
   assign consume   = s2_valid_reg && resp_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid_reg <= 1'b0;
         s1_match_reg <= '0;
         s1_data_reg  <= '0;
      end else begin
         s1_valid_reg <= accept || (s1_valid_reg && !s2_adv);
         if (accept) begin
            s1_match_reg <= match;
            s1_data_reg  <= way_data;
         end
      end
   end

   // Result fields only change when a new response lands, so they hold otherwise.
   always_ff @(posedge clock) begin
      if (reset) begin
         s2_valid_reg <= 1'b0;
         hit_reg      <= 1'b0;
         multi_reg    <= 1'b0;
         onehot_reg   <= '0;
         way_reg      <= '0;
         data_reg     <= '0;
      end else if (s2_adv) begin
         s2_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            hit_reg    <= hit_next;
            multi_reg  <= multi_next;
            onehot_reg <= onehot_next;
            way_reg    <= way_next;
            data_reg   <= data_next;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset || stats_clear) begin
         hit_cnt_reg  <= '0;
         miss_cnt_reg <= '0;
      end else if (consume) begin
         if (hit_reg) begin
            if (hit_cnt_reg != {CNT_W{1'b1}}) hit_cnt_reg <= hit_cnt_reg + CNT_W'(1);
         end else begin
            if (miss_cnt_reg != {CNT_W{1'b1}}) miss_cnt_reg <= miss_cnt_reg + CNT_W'(1);
         end
      end
   end

   assign resp_valid = s2_valid_reg;
   assign hit        = hit_reg;
   assign multi_hit  = multi_reg;
   assign hit_onehot = onehot_reg;
   assign hit_way    = way_reg;
   assign line_data  = data_reg;
   assign hit_count  = hit_cnt_reg;
   assign miss_count = miss_cnt_reg;

endmodule
